// File: rtl/instr_loader.sv
// Boot-time instruction-memory loader: packs a length-prefixed byte stream
// into 32-bit words, writes them to imem and holds the core in reset until
// the image is in.
// Ports: clk, rst (async, high); start; byte_in/byte_valid/byte_ready stream;
// mem_we/mem_addr/mem_wdata imem write port; cpu_rst, done, error status.
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int          WIDTH      = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             cpu_rst,
  output logic             done,
  output logic             error
);

  localparam logic [WIDTH-1:0] BASE = WIDTH'(BASE_ADDR);
  localparam logic [16:0]      CAP  = 17'(1) << (ADDR_WIDTH - 2);

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA,
    S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;
  localparam state_t S_FIN = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA,
    S_WRITE, S_DONE, S_ERR
  } state_t;
  localparam state_t S_FIN = S_DONE;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       lenlo_q, lenlo_d;
  logic [15:0]      n_len;
  logic             xfer;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]       acc_q, acc_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      wdata_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      lenlo_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lenlo_q <= lenlo_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign xfer  = byte_valid && byte_ready;
  assign n_len = {byte_in, lenlo_q};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lenlo_d = lenlo_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        addr_d = BASE;
        idx_d  = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        acc_d  = '0;
`endif
        if (start) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (xfer) begin
          lenlo_d = byte_in;
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          cnt_d = n_len;
          if ({1'b0, n_len} > CAP)
            state_d = S_ERR;
          else if (n_len == 16'd0)
            state_d = S_FIN;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          wdata_d[{idx_q, 3'b000} +: 8] = byte_in;
`ifdef INSTR_LOADER_CHECKSUM_EN
          acc_d = acc_q ^ byte_in;
`endif
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + WIDTH'(4);
        cnt_d  = cnt_q - 16'd1;
        idx_d  = '0;
        state_d = (cnt_q == 16'd1) ? S_FIN : S_DATA;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer)
          state_d = (byte_in == acc_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN0;
          addr_d  = BASE;
          idx_d   = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All status outputs decode from state only: no input-to-output paths.
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
`else
  assign byte_ready = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA);
`endif
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rst   = (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table of stream vectors plus
// hand sequences for error recovery, reset mid-load, reload and capacity.
module tb_instr_loader;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  instr_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          bp_viol = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      if (byte_ready) bp_viol++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    byte_valid = 0;
    repeat (gap) @(negedge clk);
    byte_in    = b;
    byte_valid = 1;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) chk("ready_timeout", 32'(byte_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    byte_valid = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  typedef struct {
    string       nm;
    int          nb;
    logic [127:0] by;
    bit          addcs;
    logic [7:0]  csb;
    int          gap;
    int          nw;
    logic [31:0] a0, d0, a1, d1;
    bit          edone;
    bit          eerr;
  } vec_t;

  vec_t v[5];
  int   base;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    v[0] = '{"two_word", 10, 128'h00100593_00A00513_0002, 1, 8'h30, 0,
             2, 32'h0, 32'h00A00513, 32'h4, 32'h00100593, 1, 0};
    v[1] = '{"two_word_gap", 10, 128'h00100593_00A00513_0002, 1, 8'h30, 1,
             2, 32'h0, 32'h00A00513, 32'h4, 32'h00100593, 1, 0};
    v[2] = '{"overflow", 2, 128'h0041, 0, 8'h00, 0,
             0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1};
    v[3] = '{"n_zero", 2, 128'h0000, 1, 8'h00, 0,
             0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0};
    v[4] = '{"csum_bad", 6, 128'h00A00513_0001, 1, 8'h00, 1,
             1, 32'h0, 32'h00A00513, 32'h0, 32'h0, !CS, CS};

    rst = 1; start = 0; byte_in = 8'hAA; byte_valid = 1;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    rst = 0;
    @(negedge clk);
    chk("idle_ready", 32'(byte_ready), 32'd0);
    byte_valid = 0;

    for (int i = 0; i < 5; i++) begin
      base = wa.size();
      pulse_start();
      for (int j = 0; j < v[i].nb; j++)
        send(v[i].by[8*j +: 8], v[i].gap);
      if (CS && v[i].addcs) send(v[i].csb, v[i].gap);
      repeat (4) @(negedge clk);
      chk({v[i].nm, "_nw"}, 32'(wa.size() - base), 32'(v[i].nw));
      if (v[i].nw >= 1 && wa.size() > base) begin
        chk({v[i].nm, "_a0"}, wa[base], v[i].a0);
        chk({v[i].nm, "_d0"}, wd[base], v[i].d0);
      end
      if (v[i].nw >= 2 && wa.size() > base + 1) begin
        chk({v[i].nm, "_a1"}, wa[base+1], v[i].a1);
        chk({v[i].nm, "_d1"}, wd[base+1], v[i].d1);
      end
      chk({v[i].nm, "_done"}, 32'(done), 32'(v[i].edone));
      chk({v[i].nm, "_err"}, 32'(error), 32'(v[i].eerr));
      chk({v[i].nm, "_cpurst"}, 32'(cpu_rst), 32'(!v[i].edone));
    end

    // ERR recovery: start clears error and re-enters LEN0.
    pulse_start();
    send(8'h41, 0);
    send(8'h00, 0);
    @(negedge clk);
    chk("ovf_err", 32'(error), 32'd1);
    byte_valid = 1;
    @(negedge clk);
    chk("err_ready", 32'(byte_ready), 32'd0);
    byte_valid = 0;
    pulse_start();
    chk("recov_err", 32'(error), 32'd0);
    chk("recov_ready", 32'(byte_ready), 32'd1);
    chk("recov_cpurst", 32'(cpu_rst), 32'd1);
    send(8'h00, 0);
    send(8'h00, 0);
    if (CS) send(8'h00, 0);
    repeat (2) @(negedge clk);
    chk("recov_done", 32'(done), 32'd1);

    // Reset mid-load after 3 data bytes.
    base = wa.size();
    pulse_start();
    send(8'h03, 0);
    send(8'h00, 0);
    send(8'h13, 0);
    send(8'h05, 0);
    send(8'hA0, 0);
    #1 rst = 1;
    #1;
    chk("mid_rst_cpurst", 32'(cpu_rst), 32'd1);
    chk("mid_rst_ready", 32'(byte_ready), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("mid_rst_nowrite", 32'(wa.size() - base), 32'd0);

    // Full reload, then start in DONE.
    base = wa.size();
    pulse_start();
    for (int j = 0; j < 10; j++) send(v[0].by[8*j +: 8], 0);
    if (CS) send(8'h30, 0);
    repeat (3) @(negedge clk);
    chk("reload_nw", 32'(wa.size() - base), 32'd2);
    chk("reload_done", 32'(done), 32'd1);
    chk("reload_cpurst", 32'(cpu_rst), 32'd0);
    start = 1;
    @(posedge clk);
    #1;
    chk("restart_cpurst", 32'(cpu_rst), 32'd1);
    chk("restart_addr", mem_addr, 32'h0);
    chk("restart_done", 32'(done), 32'd0);
    @(negedge clk);
    start = 0;

    // Capacity boundary: N = 64 fills the whole memory.
    base = wa.size();
    send(8'h40, 0);
    send(8'h00, 0);
    for (int w = 0; w < 64; w++)
      for (int b = 0; b < 4; b++)
        send(8'(4*w + b), 0);
    if (CS) send(8'h00, 0);
    repeat (3) @(negedge clk);
    chk("cap_nw", 32'(wa.size() - base), 32'd64);
    if (wa.size() >= base + 64) begin
      for (int w = 0; w < 64; w++) begin
        chk($sformatf("cap_a%0d", w), wa[base+w], 32'(4*w));
        chk($sformatf("cap_d%0d", w), wd[base+w],
            {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
      end
    end
    chk("cap_done", 32'(done), 32'd1);
    chk("bp_write_ready", 32'(bp_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
